// File: rtl/fsm_after.sv
// Overlapping "111" serial pattern detector: a four-state Moore machine that
// counts trailing ones, saturating at three, with Y decoded from state alone.
module fsm_after (
    output logic Y,
    input  logic X,
    input  logic reset,
    input  logic clk
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t state;
    state_t nextState;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
        end else begin
            state <= nextState;
        end
    end

    // Anything other than a clean 1 on X (0, X or Z) breaks the run.
    always_comb begin
        nextState = S0;
        if (X == 1'b1) begin
            case (state)
                S0:      nextState = S1;
                S1:      nextState = S2;
                S2:      nextState = S3;
                S3:      nextState = S3;
                default: nextState = S0;
            endcase
        end
    end

    assign Y = (state == S3);

endmodule

// File: tb/tb_fsm_after.sv
// Scoreboard bench for fsm_after: stimulus pushes expected Y per clock,
// an independent monitor pops and compares just after each rising edge.
module tb_fsm_after;

    logic clk;
    logic reset;
    logic X;
    logic Y;

    int checkCount;
    int failCount;
    logic expQ[$];

    fsm_after dut (
        .Y     (Y),
        .X     (X),
        .reset (reset),
        .clk   (clk)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: Y=%b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one sample on the falling edge and queue the Y expected after the next rising edge.
    task automatic applyStimulus(input logic x, input logic expY);
        @(negedge clk);
        X = x;
        expQ.push_back(expY);
    endtask

    task automatic applyVector(input logic [15:0] xs, input logic [15:0] ys, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(xs[i], ys[i]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput("stream", Y, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, Y=%b expected end of test", Y);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        failCount  = 0;
        X     = 1'b0;
        reset = 1'b1;
        #5;
        reset = 1'b0;
        #1;
        checkOutput("reset_async", Y, 1'b0);

        // Reset hold with X toggling
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            X = ~X;
            @(posedge clk);
            #1;
            checkOutput("reset_hold", Y, 1'b0);
        end
        @(negedge clk);
        X     = 1'b0;
        reset = 1'b1;

        // Main stream 0,1,1,1,1,0,0,1
        applyVector(16'b0111_1001, 16'b0001_1000, 8);
        // Back to S0, then exactly three ones
        applyStimulus(1'b0, 1'b0);
        applyVector(16'b1110, 16'b0010, 4);
        // Broken run
        applyVector(16'b11_0111, 16'b00_0001, 6);
        // Long run saturation
        applyStimulus(1'b0, 1'b0);
        applyVector(16'b11_1111_1111, 16'b00_1111_1111, 10);

        // Mid-run reset pulsed inside the high phase
        @(posedge clk);
        #3;
        checkOutput("pre_reset_high", Y, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_reset_async", Y, 1'b0);
        #4;
        reset = 1'b1;
        applyVector(16'b111, 16'b001, 3);

        // Unknown X breaks a run like a 0
        applyStimulus(1'bx, 1'b0);
        applyVector(16'b111, 16'b001, 3);
        applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() > 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fsm_after.md
# fsm_after

Moore-type serial pattern detector. It samples a 1-bit input stream `X` on each rising clock edge and asserts `Y` while the three most recent samples have all been 1. The detector overlaps, so a run of N ≥ 3 ones keeps `Y` high for N−2 consecutive cycles. It is a minimized four-state machine and acts as a standalone leaf block fed by a synchronous serial source.

## Interface
- Parameters: none.
- `clk`  input  1  system clock; all state updates occur on the rising edge.
- `reset`  input  1  reset, asynchronous and active-low.
  - `reset = 0` immediately forces the idle state and `Y = 0`.
  - Release is taken into account at the next rising `clk`.
- `X`  input  1  serial data bit; must be stable around the rising `clk` edge.
- `Y`  output  1  detect flag, registered; a pure function of the current state.
- Port order at instantiation: `Y, X, reset, clk`.

## Operation
- States, 2-bit binary encoding:
  - `S0` = 00: no trailing 1s.
  - `S1` = 01: one trailing 1.
  - `S2` = 10: two trailing 1s.
  - `S3` = 11: three or more trailing 1s.
- Transitions on rising `clk` while `reset = 1`:
  - `X = 0`: any state goes to `S0`.
  - `X = 1`: `S0`→`S1`, `S1`→`S2`, `S2`→`S3`, `S3`→`S3` (saturates).
- Output: `Y = 1` if and only if state is `S3`. `Y` is decoded from the state register only; there is no combinational path from `X` to `Y`.
- Illegal or unknown state: none is reachable with 2-bit encoding. The state register must not be left uninitialized after reset.
- Reset:
  - `reset = 0` asynchronously loads `S0`, so `Y = 0`.
  - Reset mid-run discards partial history; counting restarts from `S0`.
- X sampled as X/Z during operation: treat as 0, i.e. go to `S0`.

## Timing
- `Y` reset value: 0, asserted asynchronously within the same delta as the reset assertion.
- Latency: the third consecutive `X = 1` sample is registered at rising edge k; `Y` rises immediately after edge k (clock-to-q).
- `Y` falls after the first edge that samples `X = 0`.
- Minimum `Y` pulse is one clock cycle, for exactly three ones.
- A `reset` deassertion coincident with a rising edge: that edge is ignored, and the first sample is taken at the following edge.
- Reset asserted and `X` changing simultaneously: reset wins, giving `S0` and `Y = 0`.
- `Y` changes only on a rising `clk` or on assertion of `reset`.

## Test plan
- Reset hold: `reset = 0` for 2 cycles with `X` toggling → `Y = 0` throughout; state `S0`.
- Bench stream: 40 ns period, `X` changes on the falling edge; after release, apply `X` = 0,1,1,1,1,0,0,1 per cycle.
  - Required `Y` after each edge: 0,0,0,1,1,0,0,0.
- Exactly three ones: `X` = 1,1,1,0 → `Y` = 0,0,1,0 (single-cycle pulse).
- Broken run: `X` = 1,1,0,1,1,1 → `Y` = 0,0,0,0,0,1.
- Long run saturation: `X = 1` for 10 cycles → `Y` low for the first 2 edges, then high for 8 consecutive cycles.
- Mid-run reset: drive `X = 1` until `Y = 1`, then pulse `reset = 0` between edges.
  - `Y` drops to 0 immediately, without waiting for a clock edge.
  - After release with `X` held at 1, `Y` returns to 1 on the 3rd edge.
